branch_resolve_unit: RTL



---
 rtl/lc3b_types.sv | 24 ++
 rtl/br_pred_fifo.sv | 68 ++++++
 rtl/branch_resolve_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_types (package)
// Purpose  : Shared LC-3b types. Holds the branch resolution entry and state.
// Revision : 1.0  initial release
// ============================================================================
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        logic       taken;
        lc3b_word   target;
        logic [7:0] pc;
        logic [7:0] hist;
    } br_pred_entry_t;

    typedef enum logic [0:0] {
        BR_RUN   = 1'b0,
        BR_FLUSH = 1'b1
    } br_res_state_t;

endpackage
`default_nettype wire

// File: rtl/br_pred_fifo.sv
`default_nettype none
// ============================================================================
// Module   : br_pred_fifo
// Purpose  : In-order store of in-flight predictions; clear beats push.
// Revision : 1.0  initial release
// ============================================================================
module br_pred_fifo
    import lc3b_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic           pop,
    input  logic           clear,
    input  br_pred_entry_t din,
    output br_pred_entry_t dout,
    output logic           full,
    output logic           empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    br_pred_entry_t      r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                w_push;
    logic                w_pop;

    // A pop frees a slot, so a push into a full FIFO is accepted alongside it.
    assign w_pop  = pop & ~empty & ~clear;
    assign w_push = push & ~clear & (~full | w_pop);

    assign full  = (r_count == c_CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Retires predictions at EX/MEM: flush/redirect, predictor training,
//            committed global history. Optional stats via BR_RESOLVE_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module branch_resolve_unit
    import lc3b_types::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        pred_valid,
    input  logic        pred_taken,
    input  logic [15:0] pred_target,
    input  logic [7:0]  pred_pc,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic [15:0] res_target,
    input  logic [15:0] res_fallthrough,
    output logic        full,
    output logic        empty,
    output logic        flush,
    output logic [15:0] redirect_pc,
    output logic        upd_valid,
    output logic [7:0]  upd_index,
    output logic [7:0]  upd_pc,
    output logic        upd_taken,
    output logic [15:0] upd_target,
    output logic [7:0]  history,
    output logic        orphan,
    output logic [15:0] resolved_count,
    output logic [15:0] mispredict_count
);

    localparam logic [2:0] c_FLUSH_LOAD = 3'(FLUSH_CYCLES);

    br_res_state_t  r_state;
    br_res_state_t  w_state_next;
    logic [2:0]     r_flush_cnt;
    logic           w_flush;

    br_pred_entry_t w_head;
    br_pred_entry_t w_entry;
    br_pred_entry_t w_push_entry;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic           w_run;
    logic           w_pop_req;
    logic           w_fifo_pop;
    logic           w_fifo_push;
    logic           w_mispredict;

    logic [7:0]     r_history;
    logic           r_orphan;
    logic [15:0]    r_redirect_pc;
    logic           r_upd_valid;
    logic [7:0]     r_upd_index;
    logic [7:0]     r_upd_pc;
    logic           r_upd_taken;
    logic [15:0]    r_upd_target;

    assign w_run     = (r_state == BR_RUN);
    assign w_pop_req = res_valid & ~stall & w_run;

    // A resolution with nothing in flight is judged against a not-taken guess.
    always_comb begin
        w_entry = w_head;
        if (w_fifo_empty) begin
            w_entry.taken  = 1'b0;
            w_entry.target = 16'h0000;
            w_entry.pc     = 8'h00;
            w_entry.hist   = r_history;
        end
    end

    assign w_mispredict = w_pop_req &
                          ((w_entry.taken != res_taken) |
                           (res_taken & (w_entry.target != res_target)));

    assign w_fifo_pop  = w_pop_req & ~w_fifo_empty;
    assign w_fifo_push = pred_valid & ~stall & w_run & ~w_mispredict &
                         (~w_fifo_full | w_fifo_pop);

    assign w_push_entry = '{taken: pred_taken, target: pred_target,
                            pc: pred_pc, hist: r_history};

    br_pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_fifo_push),
        .pop   (w_fifo_pop),
        .clear (w_mispredict),
        .din   (w_push_entry),
        .dout  (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= BR_RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_mispredict) begin
                r_flush_cnt <= c_FLUSH_LOAD;
            end else if (r_state == BR_FLUSH) begin
                r_flush_cnt <= r_flush_cnt - 3'd1;
            end
        end
    end

    // The flush countdown ignores stall so the squash window is fixed length.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BR_RUN:   if (w_mispredict) w_state_next = BR_FLUSH;
            BR_FLUSH: if (r_flush_cnt == 3'd1) w_state_next = BR_RUN;
            default:  w_state_next = BR_RUN;
        endcase
    end

    always_comb begin
        w_flush = 1'b0;
        case (r_state)
            BR_FLUSH: w_flush = 1'b1;
            default:  w_flush = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_history     <= '0;
            r_orphan      <= 1'b0;
            r_redirect_pc <= '0;
            r_upd_valid   <= 1'b0;
            r_upd_index   <= '0;
            r_upd_pc      <= '0;
            r_upd_taken   <= 1'b0;
            r_upd_target  <= '0;
        end else begin
            r_upd_valid <= w_pop_req;
            if (w_pop_req) begin
                r_upd_index  <= w_entry.pc ^ w_entry.hist;
                r_upd_pc     <= w_entry.pc;
                r_upd_taken  <= res_taken;
                r_upd_target <= res_taken ? res_target : w_entry.target;
                r_history    <= {r_history[6:0], res_taken};
            end
            if (w_pop_req && w_fifo_empty) begin
                r_orphan <= 1'b1;
            end
            if (w_mispredict) begin
                r_redirect_pc <= res_taken ? res_target : res_fallthrough;
            end
        end
    end

`ifdef BR_RESOLVE_STATS_EN
    logic [15:0] r_resolved_count;
    logic [15:0] r_mispredict_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_resolved_count   <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_pop_req && (r_resolved_count != 16'hFFFF)) begin
                r_resolved_count <= r_resolved_count + 16'd1;
            end
            if (w_mispredict && (r_mispredict_count != 16'hFFFF)) begin
                r_mispredict_count <= r_mispredict_count + 16'd1;
            end
        end
    end

    assign resolved_count   = r_resolved_count;
    assign mispredict_count = r_mispredict_count;
`else
    assign resolved_count   = 16'h0000;
    assign mispredict_count = 16'h0000;
`endif

    assign full        = w_fifo_full;
    assign empty       = w_fifo_empty;
    assign flush       = w_flush;
    assign redirect_pc = r_redirect_pc;
    assign upd_valid   = r_upd_valid;
    assign upd_index   = r_upd_index;
    assign upd_pc      = r_upd_pc;
    assign upd_taken   = r_upd_taken;
    assign upd_target  = r_upd_target;
    assign history     = r_history;
    assign orphan      = r_orphan;

endmodule
`default_nettype wire
